// File: rtl/weight_bias_bank.sv
// Double-buffered kernel weight/bias store: words stream into a shadow bank and
// a commit copies every shadow kernel to the active bank that the conv datapath reads.
module weight_bias_bank #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNELS = 4,
  parameter int FRAC_BITS   = 14,
  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE,
  localparam int IDX_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic [IDX_W-1:0]         load_idx,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     load_err,
  input  logic                     commit,
  output logic                     commit_done,
  output logic                     busy,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic                     rd_valid,
  output logic [DATA_WIDTH*KK-1:0] weights,
  output logic [DATA_WIDTH-1:0]    bias
);

  localparam int CNT_W = $clog2(KK + 1);
  localparam int EW    = DATA_WIDTH * (KK + 1);

  // The fixed-point format is informational only, but an impossible split is a setup error.
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_frac_check
    $error("weight_bias_bank: FRAC_BITS must lie in [0, DATA_WIDTH)");
  end

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             commit_pending;
  logic             idx_ok, rd_ok, accept, last_word, copy_now;

  // Each entry holds the KK weights (first word in the MSBs) followed by the bias.
  logic [EW-1:0] shadow [NUM_KERNELS];
  logic [EW-1:0] active [NUM_KERNELS];

  assign idx_ok     = int'(load_idx) < NUM_KERNELS;
  assign rd_ok      = int'(rd_idx) < NUM_KERNELS;
  assign accept     = (state_q == LOAD) && load_valid;
  assign last_word  = cnt_q == CNT_W'(KK);
  assign copy_now   = (state_q == IDLE) && (commit || commit_pending);
  assign load_ready = state_q == LOAD;
  assign busy       = (state_q == LOAD) || commit_pending;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start && idx_ok) state_d = LOAD;
      LOAD:    if (accept && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      commit_pending <= 1'b0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      commit_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done   <= accept && last_word;
      load_err    <= load_start && ((state_q == LOAD) || !idx_ok);
      commit_done <= copy_now;
      if ((state_q == IDLE) && load_start && idx_ok) begin
        idx_q <= load_idx;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A commit during a load waits so the copy includes the kernel being finished.
      if (copy_now) commit_pending <= 1'b0;
      else if (commit && (state_q == LOAD)) commit_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (accept) shadow[idx_q][(KK - int'(cnt_q))*DATA_WIDTH +: DATA_WIDTH] <= load_data;
      if (copy_now) begin
        for (int k = 0; k < NUM_KERNELS; k++) active[k] <= shadow[k];
      end
    end
  end

  // A read on the copy edge sees the active bank as it was before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      weights  <= '0;
      bias     <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_ok) {weights, bias} <= active[rd_idx];
        else {weights, bias} <= '0;
      end
    end
  end

endmodule
